// File: rtl/router_pkg.sv
// Shared constants and types for the store-and-forward packet router.
package router_pkg;

    // Header layout: SA, DA, LEN (4 bytes LE), CRC (4 bytes LE), then payload
    localparam int unsigned SA_OFF    = 0;
    localparam int unsigned DA_OFF    = SA_OFF + 1;
    localparam int unsigned LEN_OFF   = DA_OFF + 1;
    localparam int unsigned CRC_OFF   = LEN_OFF + 4;
    localparam int unsigned HDR_BYTES = CRC_OFF + 4;

    localparam int unsigned DEF_MAX_PKT = 64;
    localparam int unsigned DEF_MIN_PKT = 11;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_IN_CNT   = 8'h04;
    localparam logic [7:0] ADDR_OUT_CNT  = 8'h08;
    localparam logic [7:0] ADDR_DROP_CNT = 8'h0C;

    typedef enum logic [2:0] {IDLE, RECV, CHECK, SEND, DROP} state_t;

endpackage

// File: rtl/router_csr.sv
// Register block: CTRL enable, packet statistics counters and registered read data.
module router_csr
    import router_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        pkt_in,
    input  logic        pkt_out,
    input  logic        pkt_drop,
    output logic [31:0] rdata,
    output logic        en
);

    logic        en_q, en_d;
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic [31:0] rdata_q, rdata_d;

    // Next-state for CTRL, counters and read data (read mux sees pre-write values)
    always_comb begin
        en_d       = en_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        rdata_d    = rdata_q;

        if (wr && (addr == ADDR_CTRL)) en_d = wdata[0];
        if (pkt_in)   in_cnt_d   = in_cnt_q + 32'd1;
        if (pkt_out)  out_cnt_d  = out_cnt_q + 32'd1;
        if (pkt_drop) drop_cnt_d = drop_cnt_q + 32'd1;

        if (rd) begin
            unique case (addr)
                ADDR_CTRL:     rdata_d = {31'd0, en_q};
                ADDR_IN_CNT:   rdata_d = in_cnt_q;
                ADDR_OUT_CNT:  rdata_d = out_cnt_q;
                ADDR_DROP_CNT: rdata_d = drop_cnt_q;
                default:       rdata_d = 32'd0;
            endcase
        end
    end

    // Register state; CTRL.EN comes out of reset enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q       <= 1'b1;
            in_cnt_q   <= 32'd0;
            out_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            en_q       <= en_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign en    = en_q;

endmodule

// File: rtl/router_1x1.sv
// Single-port store-and-forward packet router with header validation and statistics.
// Optional build macro ROUTER_CRC_CHECK_EN: also require CRC == 32-bit sum of payload bytes.
module router_1x1
    import router_pkg::*;
#(
    parameter int unsigned MAX_PKT = DEF_MAX_PKT,
    parameter int unsigned MIN_PKT = DEF_MIN_PKT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dut_inp,
    input  logic        inp_valid,
    output logic [7:0]  dut_outp,
    output logic        outp_valid,
    output logic        busy,
    output logic        error,
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int unsigned AW    = $clog2(MAX_PKT);
    localparam int unsigned CNT_W = AW + 2;
    localparam int unsigned IDX_W = AW + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               en_pkt_q, en_pkt_d;
    logic               ign_q, ign_d;
    logic [7:0]         dout_q, dout_d;
    logic               outp_valid_q, outp_valid_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;

    logic [7:0]         pkt_mem_q [MAX_PKT];
    logic               buf_we_c;
    logic [AW-1:0]      buf_waddr_c;
    logic               pkt_in_c, pkt_out_c, pkt_drop_c;
    logic               en_c;
    logic               crc_bad_c;
    logic               bad_c;
    logic [31:0]        len_c;

    assign len_c = {pkt_mem_q[LEN_OFF+3], pkt_mem_q[LEN_OFF+2],
                    pkt_mem_q[LEN_OFF+1], pkt_mem_q[LEN_OFF]};

`ifdef ROUTER_CRC_CHECK_EN
    logic [31:0] sum_q, sum_d;

    // Running sum of payload bytes as they are stored
    always_comb begin
        sum_d = sum_q;
        if (buf_we_c && (buf_waddr_c == '0))
            sum_d = 32'd0;
        else if (buf_we_c && (32'(buf_waddr_c) >= HDR_BYTES))
            sum_d = sum_q + 32'(dut_inp);
    end

    // Payload sum register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sum_q <= 32'd0;
        else        sum_q <= sum_d;
    end

    assign crc_bad_c = ({pkt_mem_q[CRC_OFF+3], pkt_mem_q[CRC_OFF+2],
                         pkt_mem_q[CRC_OFF+1], pkt_mem_q[CRC_OFF]} != sum_q);
`else
    assign crc_bad_c = 1'b0;
`endif

    assign bad_c = (32'(cnt_q) != len_c) || (len_c < MIN_PKT) || (len_c > MAX_PKT) || crc_bad_c;

    // Packet FSM next-state, buffer write control and registered output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        en_pkt_d     = en_pkt_q;
        ign_d        = ign_q & inp_valid;
        dout_d       = 8'd0;
        outp_valid_d = 1'b0;
        busy_d       = busy_q;
        error_d      = 1'b0;
        buf_we_c     = 1'b0;
        buf_waddr_c  = AW'(cnt_q);
        pkt_in_c     = 1'b0;
        pkt_out_c    = 1'b0;
        pkt_drop_c   = 1'b0;

        unique case (state_q)
            IDLE, DROP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                // A frame already being ignored must not be picked up mid-stream
                if (inp_valid && !ign_q) begin
                    state_d     = RECV;
                    cnt_d       = CNT_W'(1);
                    en_pkt_d    = en_c;
                    buf_we_c    = 1'b1;
                    buf_waddr_c = '0;
                end
            end
            RECV: begin
                if (inp_valid) begin
                    buf_we_c = (32'(cnt_q) < MAX_PKT);
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = CHECK;
                    busy_d   = 1'b1;
                    pkt_in_c = 1'b1;
                end
            end
            CHECK: begin
                if (!en_pkt_q) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    pkt_drop_c = 1'b1;
                end else if (bad_c) begin
                    state_d    = DROP;
                    busy_d     = 1'b0;
                    error_d    = 1'b1;
                    pkt_drop_c = 1'b1;
                end else begin
                    state_d      = SEND;
                    outp_valid_d = 1'b1;
                    dout_d       = pkt_mem_q[0];
                    idx_d        = IDX_W'(1);
                end
            end
            SEND: begin
                outp_valid_d = 1'b1;
                dout_d       = pkt_mem_q[AW'(idx_q)];
                idx_d        = idx_q + IDX_W'(1);
                if (32'(idx_q) == (len_c - 32'd1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    pkt_out_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new frame arriving while busy is ignored and flagged once
        if (((state_q == CHECK) || (state_q == SEND)) && inp_valid && !ign_q) begin
            ign_d      = 1'b1;
            error_d    = 1'b1;
            pkt_drop_c = 1'b1;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            en_pkt_q     <= 1'b0;
            ign_q        <= 1'b0;
            dout_q       <= 8'd0;
            outp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            en_pkt_q     <= en_pkt_d;
            ign_q        <= ign_d;
            dout_q       <= dout_d;
            outp_valid_q <= outp_valid_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    // Packet buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (buf_we_c) pkt_mem_q[buf_waddr_c] <= dut_inp;
    end

    router_csr u_csr (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .wdata    (wdata),
        .pkt_in   (pkt_in_c),
        .pkt_out  (pkt_out_c),
        .pkt_drop (pkt_drop_c),
        .rdata    (rdata),
        .en       (en_c)
    );

    assign dut_outp   = dout_q;
    assign outp_valid = outp_valid_q;
    assign busy       = busy_q;
    assign error      = error_q;

endmodule

// File: tb/tb_router_1x1.sv
// Directed self-checking bench for router_1x1.
module tb_router_1x1;

    typedef logic [7:0] bytes_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  dut_inp = 8'd0;
    logic        inp_valid = 1'b0;
    logic [7:0]  dut_outp;
    logic        outp_valid;
    logic        busy;
    logic        error;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_cnt = 0;
    bytes_t out_q;
    int     cyc_q [$];

    int exp_in = 0, exp_out = 0, exp_drop = 0;

    router_1x1 dut (
        .clk        (clk),
        .reset      (rst_n),
        .dut_inp    (dut_inp),
        .inp_valid  (inp_valid),
        .dut_outp   (dut_outp),
        .outp_valid (outp_valid),
        .busy       (busy),
        .error      (error),
        .wr         (wr),
        .rd         (rd),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output collector: every forwarded byte with its cycle, and error-high cycles
    always @(negedge clk) begin
        if (outp_valid === 1'b1) begin
            out_q.push_back(dut_outp);
            cyc_q.push_back(cyc);
        end
        if (error === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bytes_t gen_payload(input int unsigned n);
        bytes_t p;
        for (int i = 0; i < int'(n); i++) p.push_back(8'(i * 7 + 1));
        return p;
    endfunction

    function automatic bytes_t mk_pkt(input logic [31:0] len_field, input bytes_t pay,
                                      input bit force_crc, input logic [31:0] crc_val);
        bytes_t p;
        logic [31:0] sum = 32'd0;
        logic [31:0] crc;
        foreach (pay[i]) sum = sum + {24'd0, pay[i]};
        crc = force_crc ? crc_val : sum;
        p.push_back(8'h5A);
        p.push_back(8'hC3);
        for (int k = 0; k < 4; k++) p.push_back(len_field[8*k +: 8]);
        for (int k = 0; k < 4; k++) p.push_back(crc[8*k +: 8]);
        foreach (pay[i]) p.push_back(pay[i]);
        return p;
    endfunction

    task automatic send_pkt(input bytes_t p, output int fall_cyc);
        foreach (p[i]) begin
            @(negedge clk);
            inp_valid = 1'b1;
            dut_inp   = p[i];
        end
        @(negedge clk);
        inp_valid = 1'b0;
        dut_inp   = 8'd0;
        fall_cyc  = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic chk_counters(input string tag);
        logic [31:0] v;
        reg_rd(8'h04, v); chk({tag, "_in_cnt"}, v, 32'(exp_in));
        reg_rd(8'h08, v); chk({tag, "_out_cnt"}, v, 32'(exp_out));
        reg_rd(8'h0C, v); chk({tag, "_drop_cnt"}, v, 32'(exp_drop));
    endtask

    // Compare forwarded bytes, start latency, gap-free framing and error pulses
    task automatic chk_fwd(input string tag, input bytes_t p, input int fall,
                           input int base, input int ebase, input int exp_err);
        int n;
        idle(p.size() + 6);
        n = out_q.size() - base;
        chk({tag, "_nbytes"}, 32'(n), 32'(p.size()));
        chk({tag, "_err_cycles"}, 32'(err_cnt - ebase), 32'(exp_err));
        if (n >= p.size() && p.size() > 0) begin
            chk({tag, "_latency"}, 32'(cyc_q[base] - fall), 32'd2);
            chk({tag, "_no_gaps"}, 32'(cyc_q[base + p.size() - 1] - cyc_q[base]), 32'(p.size() - 1));
            foreach (p[i]) chk($sformatf("%s_byte%0d", tag, i), 32'(out_q[base + i]), 32'(p[i]));
        end
    endtask

    // Packet that must be dropped or swallowed: no output, given error cycles
    task automatic chk_none(input string tag, input int base, input int ebase, input int exp_err);
        idle(20);
        chk({tag, "_nbytes"}, 32'(out_q.size() - base), 32'd0);
        chk({tag, "_err_cycles"}, 32'(err_cnt - ebase), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bytes_t p, p2;
        int fall, fall2, base, eb, n;
        logic [31:0] v;

        // Reset values
        #2 rst_n = 1'b0;
        idle(3);
        chk("rst_outp", 32'(dut_outp), 32'd0);
        chk("rst_outp_valid", 32'(outp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        idle(2);
        reg_rd(8'h00, v); chk("rst_ctrl", v, 32'd1);
        chk_counters("rst");

        // 1: 16-byte packet, correct LEN and CRC
        p = mk_pkt(32'd16, gen_payload(6), 1'b0, 32'd0);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        @(negedge clk);
        chk("t1_busy_in_check", 32'(busy), 32'd1);
        chk_fwd("t1", p, fall, base, eb, 0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        exp_in++; exp_out++;
        chk_counters("t1");

        // 2: LEN=20 but only 16 bytes
        p = mk_pkt(32'd20, gen_payload(6), 1'b0, 32'd0);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        chk_none("t2", base, eb, 1);
        exp_in++; exp_drop++;
        chk_counters("t2");

        // 3: disabled router swallows silently, re-enabled forwards
        reg_wr(8'h00, 32'd0);
        reg_rd(8'h00, v); chk("t3_ctrl_off", v, 32'd0);
        p = mk_pkt(32'd12, gen_payload(2), 1'b0, 32'd0);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        chk_none("t3_dis", base, eb, 0);
        exp_in++; exp_drop++;
        reg_wr(8'h00, 32'd1);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        chk_fwd("t3_en", p, fall, base, eb, 0);
        exp_in++; exp_out++;
        chk_counters("t3");

        // LEN boundaries: below minimum, exactly maximum, above maximum
        p = mk_pkt(32'd10, gen_payload(0), 1'b0, 32'd0);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        chk_none("len10", base, eb, 1);
        exp_in++; exp_drop++;
        p = mk_pkt(32'd64, gen_payload(54), 1'b0, 32'd0);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        chk_fwd("len64", p, fall, base, eb, 0);
        exp_in++; exp_out++;
        p = mk_pkt(32'd65, gen_payload(55), 1'b0, 32'd0);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        chk_none("len65", base, eb, 1);
        exp_in++; exp_drop++;
        chk_counters("len");

        // 4: second packet while busy is ignored, first one intact
        p  = mk_pkt(32'd16, gen_payload(6), 1'b0, 32'd0);
        p2 = mk_pkt(32'd12, gen_payload(2), 1'b0, 32'd0);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        idle(2);
        send_pkt(p2, fall2);
        chk_fwd("t4", p, fall, base, eb, 1);
        exp_in++; exp_out++; exp_drop++;
        reg_rd(8'h08, v); chk("t4_out_cnt", v, 32'(exp_out));
        reg_rd(8'h0C, v); chk("t4_drop_cnt", v, 32'(exp_drop));

        // Register corner cases
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 32'd0;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        chk("rdwr_prewrite", rdata, 32'd1);
        reg_rd(8'h00, v); chk("rdwr_postwrite", v, 32'd0);
        reg_wr(8'h00, 32'd1);
        reg_wr(8'h08, 32'hDEAD_BEEF);
        reg_rd(8'h08, v); chk("ro_write_ignored", v, 32'(exp_out));
        reg_wr(8'h10, 32'hFFFF_FFFF);
        reg_rd(8'h10, v); chk("unmapped_read", v, 32'd0);

        // 5: CRC field, payload {01,02,03}
        p2 = {};
        p2.push_back(8'h01); p2.push_back(8'h02); p2.push_back(8'h03);
        p = mk_pkt(32'd13, p2, 1'b1, 32'd7);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
`ifdef ROUTER_CRC_CHECK_EN
        chk_none("t5_crc7", base, eb, 1);
        exp_in++; exp_drop++;
`else
        chk_fwd("t5_crc7", p, fall, base, eb, 0);
        exp_in++; exp_out++;
`endif
        p = mk_pkt(32'd13, p2, 1'b1, 32'd6);
        base = out_q.size(); eb = err_cnt;
        send_pkt(p, fall);
        chk_fwd("t5_crc6", p, fall, base, eb, 0);
        exp_in++; exp_out++;
        chk_counters("t5");

        // 6: reset during SEND
        reg_rd(8'h08, v);
        p = mk_pkt(32'd16, gen_payload(6), 1'b0, 32'd0);
        send_pkt(p, fall);
        n = 0;
        while (outp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_sending", 32'(outp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_outp", 32'(dut_outp), 32'd0);
        chk("t6_outp_valid", 32'(outp_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        reg_rd(8'h00, v); chk("t6_ctrl", v, 32'd1);
        exp_in = 0; exp_out = 0; exp_drop = 0;
        chk_counters("t6");
        chk("t6_idle_outp_valid", 32'(outp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
